multi_wave_gen: RTL and testbench

MULTI_WAVE_GEN -- requirements
Module: multi_wave_gen

---
 rtl/multi_wave_gen.sv | 96 +++++++++
 tb/tb_multi_wave_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_wave_gen.sv
// multi_wave_gen: NCH independent PWM channels with shadowed, period-boundary-aligned reconfiguration.
// Define MULTI_WAVE_GEN_IRQ_EN to add sticky per-channel period interrupts (irq_clr/irq_status/irq).
module multi_wave_gen #(
  parameter int NCH = 4,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]       cfg_period,
  input  logic [CNT_W-1:0]       cfg_high,
  input  logic                   cfg_en,
`ifdef MULTI_WAVE_GEN_IRQ_EN
  input  logic [NCH-1:0]         irq_clr,
  output logic [NCH-1:0]         irq_status,
  output logic                   irq,
`endif
  output logic [NCH-1:0]         wave,
  output logic [NCH-1:0]         period_tick
);
  localparam int CH_W = $clog2(NCH);
  localparam int PW = 1 << CH_W;
  logic [NCH-1:0] pend;
  logic [PW-1:0] pend_all;
  // Zero-extended so out-of-range channel indices read as "not pending" and are accepted.
  assign pend_all = PW'(pend);
  assign cfg_ready = rst_n && !pend_all[cfg_ch];
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, high_q, high_d, sper_q, sper_d, shigh_q, shigh_d;
    logic en_q, en_d, sen_q, sen_d, pend_q, pend_d, acc, bnd;
    assign acc = cfg_valid && cfg_ready && cfg_ch == CH_W'(g);
    assign bnd = en_q && cnt_q == per_q;
    always_comb begin
      cnt_d = '0;
      per_d = per_q;
      high_d = high_q;
      en_d = en_q;
      sper_d = sper_q;
      shigh_d = shigh_q;
      sen_d = sen_q;
      pend_d = pend_q;
      if (en_q && !bnd) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (acc) begin
          sper_d = cfg_period;
          shigh_d = cfg_high;
          sen_d = cfg_en;
          pend_d = 1'b1;
        end
      end else if (acc) begin
        per_d = cfg_period;
        high_d = cfg_high;
        en_d = cfg_en;
      end else if (pend_q) begin
        per_d = sper_q;
        high_d = shigh_q;
        en_d = sen_q;
        pend_d = 1'b0;
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
        per_q <= '0;
        high_q <= '0;
        en_q <= 1'b0;
        sper_q <= '0;
        shigh_q <= '0;
        sen_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        per_q <= per_d;
        high_q <= high_d;
        en_q <= en_d;
        sper_q <= sper_d;
        shigh_q <= shigh_d;
        sen_q <= sen_d;
        pend_q <= pend_d;
      end
    end
    assign wave[g] = en_q && cnt_q < high_q;
    assign period_tick[g] = bnd;
    assign pend[g] = pend_q;
  end
`ifdef MULTI_WAVE_GEN_IRQ_EN
  logic [NCH-1:0] irq_q, irq_d;
  // A tick in the same cycle as a clear keeps the bit set.
  assign irq_d = (irq_q & ~irq_clr) | period_tick;
  always_ff @(posedge clk) irq_q <= rst_n ? irq_d : '0;
  assign irq_status = irq_q;
  assign irq = |irq_q;
`endif
endmodule

// File: tb/tb_multi_wave_gen.sv
// tb_multi_wave_gen: randomized and directed checks against a period-arithmetic reference model.
// Channel count 5 leaves cfg_ch codes 5..7 available to exercise discarded writes.
module tb_multi_wave_gen;
  localparam int NCH = 5;
  localparam int CNT_W = 8;
  localparam int CH_W = $clog2(NCH);
  logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, cfg_ready, cfg_en = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [CNT_W-1:0] cfg_period = '0, cfg_high = '0;
  logic [NCH-1:0] wave, period_tick;
`ifdef MULTI_WAVE_GEN_IRQ_EN
  logic [NCH-1:0] irq_clr = '0, irq_status, m_irq = '0;
  logic irq;
`endif
  int n_cmp = 0, n_err = 0, t = 0;
  int m_per[NCH], m_high[NCH], m_start[NCH], s_per[NCH], s_high[NCH];
  bit m_en[NCH], m_pend[NCH], s_en[NCH];
  bit last_acc = 1'b0;

  always #5 clk = ~clk;

  multi_wave_gen #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_en(cfg_en),
`ifdef MULTI_WAVE_GEN_IRQ_EN
    .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq),
`endif
    .wave(wave), .period_tick(period_tick)
  );

  // Position inside the current period, derived from when that period shape started.
  function automatic int phase(int i);
    return m_en[i] ? (t - m_start[i]) % (m_per[i] + 1) : 0;
  endfunction

  function automatic logic [NCH-1:0] exp_wave();
    logic [NCH-1:0] r = '0;
    for (int i = 0; i < NCH; i++) r[i] = m_en[i] && phase(i) < m_high[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] r = '0;
    for (int i = 0; i < NCH; i++) r[i] = m_en[i] && phase(i) == m_per[i];
    return r;
  endfunction

  function automatic logic exp_ready();
    logic r = rst_n;
    for (int i = 0; i < NCH; i++) if (int'(cfg_ch) == i && m_pend[i]) r = 1'b0;
    return r;
  endfunction

  function automatic void model_upd();
    logic [NCH-1:0] tk = exp_tick();
    last_acc = cfg_valid && exp_ready();
    for (int i = 0; i < NCH; i++) begin
      bit acc;
      acc = last_acc && int'(cfg_ch) == i;
      if (!rst_n) begin
        m_per[i] = 0; m_high[i] = 0; m_en[i] = 0; m_pend[i] = 0;
        s_per[i] = 0; s_high[i] = 0; s_en[i] = 0; m_start[i] = t + 1;
      end else if (!m_en[i] || tk[i]) begin
        if (acc) begin
          m_per[i] = int'(cfg_period); m_high[i] = int'(cfg_high); m_en[i] = cfg_en;
        end else if (m_pend[i]) begin
          m_per[i] = s_per[i]; m_high[i] = s_high[i]; m_en[i] = s_en[i]; m_pend[i] = 0;
        end
        m_start[i] = t + 1;
      end else if (acc) begin
        s_per[i] = int'(cfg_period); s_high[i] = int'(cfg_high); s_en[i] = cfg_en; m_pend[i] = 1;
      end
    end
`ifdef MULTI_WAVE_GEN_IRQ_EN
    m_irq = rst_n ? ((m_irq & ~irq_clr) | tk) : '0;
`endif
    t++;
  endfunction

  task automatic adv(int n);
    repeat (n) begin
      model_upd();
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(int ch, int per, int hi, bit en);
    cfg_valid = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_period = CNT_W'(per);
    cfg_high = CNT_W'(hi);
    cfg_en = en;
  endtask

  task automatic wait_phase(int ch, int p);
    int n = 0;
    while (phase(ch) != p && n < 100) begin
      adv(1);
      n++;
    end
    if (phase(ch) != p) begin
      n_cmp++; n_err++;
      $display("FAIL wait_phase ch%0d: phase %0d, required %0d", ch, phase(ch), p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    adv(3);
    #1;
    n_cmp++;
    if ({cfg_ready, period_tick, wave} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got %b, required 0", {cfg_ready, period_tick, wave});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({cfg_ready, period_tick, wave} !== {1'b1, {2*NCH{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_release: got %b, required ready=1 rest 0", {cfg_ready, period_tick, wave});
    end
    adv(1);
  endtask

  task automatic test_basic();
    set_cfg(0, 9, 5, 1);
    for (int k = -1; k < 30; k++) begin
      #1;
      n_cmp++;
      if ({cfg_ready, period_tick, wave} !== {exp_ready(), exp_tick(), exp_wave()}) begin
        n_err++;
        $display("FAIL basic_model k=%0d: got %b, required %b", k, {cfg_ready, period_tick, wave},
                 {exp_ready(), exp_tick(), exp_wave()});
      end
      if (k >= 0) begin
        n_cmp++;
        if ({period_tick[0], wave[0]} !== {k % 10 == 9, k % 10 < 5}) begin
          n_err++;
          $display("FAIL basic_shape k=%0d: tick/wave %b, required %b", k, {period_tick[0], wave[0]},
                   {k % 10 == 9, k % 10 < 5});
        end
      end
      adv(1);
      cfg_valid = 1'b0;
    end
  endtask

  task automatic test_update();
    int low_n = 0, hs = 0;
    logic [1:0] e;
    wait_phase(0, 3);
    set_cfg(0, 3, 2, 1);
    for (int k = 0; k < 30; k++) begin
      #1;
      if (cfg_valid && cfg_ready) hs++;
      if (k >= 1 && k <= 6 && cfg_ready === 1'b0) low_n++;
      n_cmp++;
      if ({cfg_ready, period_tick, wave} !== {exp_ready(), exp_tick(), exp_wave()}) begin
        n_err++;
        $display("FAIL update_model k=%0d: got %b, required %b", k, {cfg_ready, period_tick, wave},
                 {exp_ready(), exp_tick(), exp_wave()});
      end
      e = k <= 6 ? {k == 6, k < 2} : k <= 10 ? {k == 10, k < 9} : {(k - 11) % 6 == 5, (k - 11) % 6 == 0};
      n_cmp++;
      if ({period_tick[0], wave[0]} !== e) begin
        n_err++;
        $display("FAIL update_shape k=%0d: tick/wave %b, required %b", k, {period_tick[0], wave[0]}, e);
      end
      adv(1);
      if (k == 0) begin
        cfg_period = CNT_W'(5);
        cfg_high = CNT_W'(1);
      end else if (last_acc) cfg_valid = 1'b0;
    end
    n_cmp++;
    if (low_n != 6 || hs != 2) begin
      n_err++;
      $display("FAIL update_handshake: ready-low %0d handshakes %0d, required 6 and 2", low_n, hs);
    end
  endtask

  task automatic test_edges();
    set_cfg(2, 0, 1, 1);
    adv(1);
    set_cfg(3, 7, 0, 1);
    adv(1);
    set_cfg(4, 9, 20, 1);
    adv(1);
    set_cfg(NCH, 3, 3, 1);
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL edge_oob_ready: got %b, required 1", cfg_ready);
    end
    adv(1);
    cfg_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_cmp++;
      if ({cfg_ready, period_tick, wave} !== {exp_ready(), exp_tick(), exp_wave()}) begin
        n_err++;
        $display("FAIL edge_model k=%0d: got %b, required %b", k, {cfg_ready, period_tick, wave},
                 {exp_ready(), exp_tick(), exp_wave()});
      end
      n_cmp++;
      if ({wave[4], wave[3], period_tick[2], wave[2]} !== 4'b1011) begin
        n_err++;
        $display("FAIL edge_const k=%0d: got %b, required 1011", k,
                 {wave[4], wave[3], period_tick[2], wave[2]});
      end
      adv(1);
    end
  endtask

  task automatic test_disable();
    set_cfg(1, 8, 5, 1);
    adv(1);
    cfg_valid = 1'b0;
    wait_phase(1, 2);
    set_cfg(1, 8, 5, 0);
    for (int k = 0; k < 20; k++) begin
      #1;
      n_cmp++;
      if ({cfg_ready, period_tick, wave} !== {exp_ready(), exp_tick(), exp_wave()}) begin
        n_err++;
        $display("FAIL disable_model k=%0d: got %b, required %b", k, {cfg_ready, period_tick, wave},
                 {exp_ready(), exp_tick(), exp_wave()});
      end
      n_cmp++;
      if ({period_tick[1], wave[1]} !== {k == 6, k < 3}) begin
        n_err++;
        $display("FAIL disable_shape k=%0d: tick/wave %b, required %b", k, {period_tick[1], wave[1]},
                 {k == 6, k < 3});
      end
      adv(1);
      cfg_valid = 1'b0;
    end
    wait_phase(0, 2);
    set_cfg(0, 4, 4, 1);
    adv(1);
    cfg_valid = 1'b0;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pend_before_reset: ready %b, required 0", cfg_ready);
    end
    rst_n = 1'b0;
    adv(1);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({cfg_ready, period_tick, wave} !== {1'b1, {2*NCH{1'b0}}}) begin
      n_err++;
      $display("FAIL midrun_reset: got %b, required ready=1 rest 0", {cfg_ready, period_tick, wave});
    end
    adv(1);
  endtask

  task automatic test_irq();
`ifdef MULTI_WAVE_GEN_IRQ_EN
    set_cfg(0, 3, 1, 1);
    adv(1);
    cfg_valid = 1'b0;
    wait_phase(0, 3);
    adv(4);
    irq_clr = NCH'(1);
    #1;
    n_cmp++;
    if ({period_tick[0], irq_status[0]} !== 2'b11) begin
      n_err++;
      $display("FAIL irq_pre: tick/status %b, required 11", {period_tick[0], irq_status[0]});
    end
    adv(1);
    irq_clr = '0;
    #1;
    n_cmp++;
    if (irq_status[0] !== 1'b1 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set_wins: status %b irq %b, required 1 1", irq_status[0], irq);
    end
    irq_clr = NCH'(1);
    adv(1);
    irq_clr = '0;
    #1;
    n_cmp++;
    if (irq_status !== '0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: status %b irq %b, required 0 0", irq_status, irq);
    end
    adv(1);
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if (!(cfg_valid && !last_acc)) begin
        cfg_valid = $urandom_range(0, 2) == 0;
        cfg_ch = CH_W'($urandom_range(0, 7));
        cfg_period = CNT_W'($urandom_range(0, 12));
        cfg_high = CNT_W'($urandom_range(0, 15));
        cfg_en = $urandom_range(0, 3) != 0;
      end
      rst_n = $urandom_range(0, 299) != 0;
`ifdef MULTI_WAVE_GEN_IRQ_EN
      irq_clr = NCH'($urandom);
`endif
      #1;
      n_cmp++;
      if ({cfg_ready, period_tick, wave} !== {exp_ready(), exp_tick(), exp_wave()}) begin
        n_err++;
        $display("FAIL random_model k=%0d: got %b, required %b", k, {cfg_ready, period_tick, wave},
                 {exp_ready(), exp_tick(), exp_wave()});
      end
`ifdef MULTI_WAVE_GEN_IRQ_EN
      n_cmp++;
      if ({irq, irq_status} !== {|m_irq, m_irq}) begin
        n_err++;
        $display("FAIL random_irq k=%0d: got %b, required %b", k, {irq, irq_status}, {|m_irq, m_irq});
      end
`endif
      adv(1);
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_update();
    test_edges();
    test_disable();
    test_irq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
